gon_scatter_ctrl: RTL

- Sequencer that feeds the global-on-chip network (GON) from a source buffer (GLB read port).
- For each transfer job it walks a rectangular range of row tags × column tags, sending a fixed number of words per tag pair.
- It drives the GON's shared data bus, row_tag, col_tag and enable, and obeys the GON's aggregated ready.
- One job at a time; a start pulse launches a job and a done pulse ends it.

---
 rtl/gon_scatter_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/gon_scatter_ctrl.sv
// GON scatter sequencer: walks a row-tag x col-tag range, sending a fixed
// number of source words per tag pair through a single-entry output register.
module gon_scatter_ctrl #(
   parameter int DATA_WIDTH    = 64,
   parameter int ROW_TAG_WIDTH = 4,
   parameter int COL_TAG_WIDTH = 4,
   parameter int CNT_WIDTH     = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [ROW_TAG_WIDTH-1:0] cfg_row_first,
   input  logic [ROW_TAG_WIDTH-1:0] cfg_row_last,
   input  logic [COL_TAG_WIDTH-1:0] cfg_col_first,
   input  logic [COL_TAG_WIDTH-1:0] cfg_col_last,
   input  logic [CNT_WIDTH-1:0]     cfg_words,
   input  logic                     src_valid,
   input  logic [DATA_WIDTH-1:0]    src_data,
   output logic                     src_ready,
   input  logic                     gon_ready,
   output logic                     gon_enable,
   output logic [DATA_WIDTH-1:0]    gon_data,
   output logic [ROW_TAG_WIDTH-1:0] row_tag,
   output logic [COL_TAG_WIDTH-1:0] col_tag,
   output logic                     busy,
   output logic                     done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                   state;
   logic [ROW_TAG_WIDTH-1:0] row_cnt, row_last_q;
   logic [COL_TAG_WIDTH-1:0] col_cnt, col_first_q, col_last_q;
   logic [CNT_WIDTH-1:0]     word_cnt, word_last_q;
   logic                     fetch_done;
   logic                     fetch, xfer, last_fetch;

   always_comb begin
      src_ready  = (state == SEND) && !fetch_done && (!gon_enable || gon_ready);
      fetch      = src_valid && src_ready;
      xfer       = gon_enable && gon_ready;
      last_fetch = (row_cnt == row_last_q) && (col_cnt == col_last_q) &&
                   (word_cnt == word_last_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         row_cnt     <= '0;
         row_last_q  <= '0;
         col_cnt     <= '0;
         col_first_q <= '0;
         col_last_q  <= '0;
         word_cnt    <= '0;
         word_last_q <= '0;
         fetch_done  <= 1'b0;
         gon_enable  <= 1'b0;
         gon_data    <= '0;
         row_tag     <= '0;
         col_tag     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  // Clamp degenerate ranges once here so the walk never needs to.
                  row_last_q  <= (cfg_row_last < cfg_row_first) ? cfg_row_first : cfg_row_last;
                  col_first_q <= cfg_col_first;
                  col_last_q  <= (cfg_col_last < cfg_col_first) ? cfg_col_first : cfg_col_last;
                  word_last_q <= (cfg_words == '0) ? '0 : cfg_words - CNT_WIDTH'(1);
                  row_cnt     <= cfg_row_first;
                  col_cnt     <= cfg_col_first;
                  word_cnt    <= '0;
                  fetch_done  <= 1'b0;
                  busy        <= 1'b1;
                  state       <= SEND;
               end
            end
            SEND: begin
               if (fetch) begin
                  gon_data   <= src_data;
                  row_tag    <= row_cnt;
                  col_tag    <= col_cnt;
                  gon_enable <= 1'b1;
                  // Counters hold on the final fetch so all-ones tags never wrap.
                  if (last_fetch) begin
                     fetch_done <= 1'b1;
                  end else if (word_cnt != word_last_q) begin
                     word_cnt <= word_cnt + CNT_WIDTH'(1);
                  end else begin
                     word_cnt <= '0;
                     if (col_cnt != col_last_q) begin
                        col_cnt <= col_cnt + COL_TAG_WIDTH'(1);
                     end else begin
                        col_cnt <= col_first_q;
                        row_cnt <= row_cnt + ROW_TAG_WIDTH'(1);
                     end
                  end
               end else if (xfer) begin
                  gon_enable <= 1'b0;
               end
               if (fetch_done && xfer) begin
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
